// File: rtl/picorv32_axi_arbiter_pkg.sv
// Shared types and constants for the two-requester PicoRV32 AXI4-Lite arbiter.
package picorv32_axi_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [2:0] AXI_PROT_DATA  = 3'b000;
    localparam logic [2:0] AXI_PROT_INSTR = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } arb_state_e;

endpackage

// File: rtl/picorv32_axi_arbiter_if.sv
// AXI4-Lite master-port bundle shared by the arbiter and the downstream slave.
interface picorv32_axi_arbiter_if;

    logic        mem_axi_awvalid;
    logic        mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;

    logic        mem_axi_wvalid;
    logic        mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;

    logic        mem_axi_bvalid;
    logic        mem_axi_bready;

    logic        mem_axi_arvalid;
    logic        mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;

    logic        mem_axi_rvalid;
    logic        mem_axi_rready;
    logic [31:0] mem_axi_rdata;

    modport master (
        output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        output mem_axi_bready,
        output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        output mem_axi_rready,
        input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
        input  mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
    );

    modport slave (
        input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        input  mem_axi_bready,
        input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        input  mem_axi_rready,
        output mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
        output mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
    );

endinterface

// File: rtl/picorv32_axi_arbiter_rr_arbiter_2.sv
// Two-input round-robin grant; the priority pointer flips away from the winner on advance.
module rr_arbiter_2
    import picorv32_axi_pkg::*;
#(
    parameter int RESET_GRANT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               gnt,
    output logic               any_req
);

    logic prio_q;

    always_comb begin
        any_req = |req;
        gnt     = (req == 2'b11) ? prio_q : req[1];
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset)
            prio_q <= 1'(RESET_GRANT);
        else if (advance)
            prio_q <= ~gnt;
    end

endmodule

// File: rtl/picorv32_axi_arbiter.sv
// Shares one AXI4-Lite master between two PicoRV32 native memory ports, one transaction at a time.
module picorv32_axi_arbiter
    import picorv32_axi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int RESET_GRANT    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       rq_valid,
    input  logic [NUM_REQ-1:0]       rq_instr,
    input  logic [NUM_REQ-1:0][31:0] rq_addr,
    input  logic [NUM_REQ-1:0][31:0] rq_wdata,
    input  logic [NUM_REQ-1:0][3:0]  rq_wstrb,
    output logic [NUM_REQ-1:0]       rq_ready,
    output logic [31:0]              rq_rdata,
    output logic                     timeout_err,
    picorv32_axi_arbiter_if.master   axi
);

    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int CW      = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

    arb_state_e  state_q, state_d;
    logic        gnt_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic        awvalid_q, wvalid_q, arvalid_q;
    logic [CW-1:0] wd_cnt;

    logic arb_gnt, arb_any, advance;
    logic in_resp, resp, expire, done;

    rr_arbiter_2 #(.RESET_GRANT(RESET_GRANT)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (rq_valid),
        .advance (advance),
        .gnt     (arb_gnt),
        .any_req (arb_any)
    );

    assign axi.mem_axi_awvalid = awvalid_q;
    assign axi.mem_axi_awaddr  = addr_q;
    assign axi.mem_axi_awprot  = AXI_PROT_DATA;
    assign axi.mem_axi_wvalid  = wvalid_q;
    assign axi.mem_axi_wdata   = wdata_q;
    assign axi.mem_axi_wstrb   = wstrb_q;
    assign axi.mem_axi_arvalid = arvalid_q;
    assign axi.mem_axi_araddr  = addr_q;
    assign axi.mem_axi_arprot  = instr_q ? AXI_PROT_INSTR : AXI_PROT_DATA;
    assign axi.mem_axi_bready  = (state_q == WRESP) && axi.mem_axi_bvalid;
    assign axi.mem_axi_rready  = (state_q == RDATA) && axi.mem_axi_rvalid;

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d  = state_q;
        advance  = 1'b0;
        rq_ready = '0;
        rq_rdata = '0;

        in_resp = (state_q == WRESP) || (state_q == RDATA);
        resp    = ((state_q == WRESP) && axi.mem_axi_bvalid) ||
                  ((state_q == RDATA) && axi.mem_axi_rvalid);
        expire  = (TIMEOUT_CYCLES != 0) && in_resp && !resp && (wd_cnt == CW'(TO_LAST));
        done    = resp || expire;

        case (state_q)
            IDLE: if (arb_any) begin
                advance = 1'b1;
                state_d = (rq_wstrb[arb_gnt] != 4'b0) ? WADDR : RADDR;
            end
            WADDR: if ((!awvalid_q || axi.mem_axi_awready) && (!wvalid_q || axi.mem_axi_wready))
                state_d = WRESP;
            RADDR: if (arvalid_q && axi.mem_axi_arready)
                state_d = RDATA;
            WRESP, RDATA: if (done)
                state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A requester that dropped valid mid-transaction simply never sees its response.
        if (done)
            rq_ready[gnt_q] = rq_valid[gnt_q];
        if ((state_q == RDATA) && axi.mem_axi_rvalid)
            rq_rdata = axi.mem_axi_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            instr_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;

            if (axi.mem_axi_awready) awvalid_q <= 1'b0;
            if (axi.mem_axi_wready)  wvalid_q  <= 1'b0;
            if (axi.mem_axi_arready) arvalid_q <= 1'b0;

            if ((state_q == IDLE) && arb_any) begin
                gnt_q   <= arb_gnt;
                addr_q  <= rq_addr[arb_gnt];
                wdata_q <= rq_wdata[arb_gnt];
                wstrb_q <= rq_wstrb[arb_gnt];
                instr_q <= rq_instr[arb_gnt];
                if (rq_wstrb[arb_gnt] != 4'b0) begin
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                end else begin
                    arvalid_q <= 1'b1;
                end
            end

            // Counter sits at zero outside the response states, so entry always starts from zero.
            if (in_resp)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;

            if (expire)
                timeout_err <= 1'b1;
        end
    end

endmodule
